// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage of the RV32I core. Holds the fetch PC, issues word
// reads to instruction memory over a req/gnt/rvalid handshake (at most one
// request outstanding), and buffers returned words with their PCs in a small
// FIFO that feeds decode over a valid/ready interface. A redirect from execute
// (taken branch / jal / jalr) flushes everything buffered or in flight and
// restarts fetch at the redirect target.
//
// Parameters:
//   RESET_PC    fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk, reset_n       core clock, asynchronous active-low reset
//   en_pc              fetch enable; low blocks new requests
//   imem_req/addr      request to instruction memory (addr word aligned)
//   imem_gnt           request accepted this cycle
//   imem_rvalid/rdata  read response (at least one cycle after gnt)
//   redirect_valid/pc  one-cycle redirect pulse and target
//   instr_valid/ready  handshake towards decode
//   instr, instr_pc    FIFO head word and its PC (NOP / 0 when empty)
//   opcode             instr[6:0] for the control unit
//   misalign_fault     misaligned redirect target seen
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a non word-aligned
//                           target raises misalign_fault and halts fetch until
//                           an aligned redirect arrives. When undefined the
//                           fault output is tied low and the low target bits
//                           are ignored.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic        misalign_fault
);

  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic             req_q;

  logic [31:0]      fifo_pc   [FIFO_DEPTH];
  logic [31:0]      fifo_word [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             pop;
  logic             push;
  logic [CNT_W-1:0] count_nxt;
  logic             halt_nxt;
  logic             issue_ok;
  logic [31:0]      redirect_target;

  // Target is always forced to a word boundary; with the trap build a
  // misaligned target additionally halts fetch through halt_nxt.
  assign redirect_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  // The fault is re-evaluated on every redirect: misaligned sets it, aligned
  // clears it. While set, no new request may issue.
  always_comb begin
    halt_nxt = fault_q;
    if (redirect_valid) begin
      halt_nxt = (redirect_pc[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= halt_nxt;
    end
  end

  assign misalign_fault = fault_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halt_nxt             = 1'b0;
  assign misalign_fault       = 1'b0;
`endif

  // A redirect wins over everything: the FIFO is emptied, so any pop or push
  // in the same cycle must be suppressed. Responses are only kept in WAIT;
  // in DROP or IDLE they belong to a squashed or pre-reset request.
  always_comb begin
    pop       = instr_valid & instr_ready & ~redirect_valid;
    push      = (state == WAIT) & imem_rvalid & ~redirect_valid;
    count_nxt = count;
    if (redirect_valid) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // The issue decision is only ever taken at points where the outstanding
  // request has just completed (or none existed), so the outstanding term of
  // "count + outstanding < depth" is zero there and the post-update count is
  // all that matters. Using the post-update count lets a pop free a slot for
  // the next request one cycle earlier; the path from instr_ready still ends
  // in a flop, so imem_req stays registered.
  assign issue_ok = en_pc & ~halt_nxt & (count_nxt < CNT_W'(FIFO_DEPTH));

  // Fetch FSM. imem_req is kept as its own flop, set exactly when the next
  // state is REQ. fetch_pc advances on grant, so while WAIT is pending the
  // returned word belongs to fetch_pc - 4.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      case (state)
        IDLE: begin
          state <= issue_ok ? REQ : IDLE;
          req_q <= issue_ok;
        end
        REQ: begin
          if (imem_gnt) begin
            state <= DROP;
            req_q <= 1'b0;
          end else if (halt_nxt) begin
            state <= IDLE;
            req_q <= 1'b0;
          end else begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        WAIT, DROP: begin
          if (imem_rvalid) begin
            state <= issue_ok ? REQ : IDLE;
            req_q <= issue_ok;
          end else begin
            state <= DROP;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          state <= issue_ok ? REQ : IDLE;
          req_q <= issue_ok;
        end
        REQ: begin
          if (imem_gnt) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
            req_q    <= 1'b0;
          end
        end
        WAIT, DROP: begin
          if (imem_rvalid) begin
            state <= issue_ok ? REQ : IDLE;
            req_q <= issue_ok;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping. A flush simply rewinds both pointers; stale storage is
  // never visible because instr_valid follows count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // FIFO storage needs no reset; entries are only read while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc - 32'd4;
      fifo_word[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_word[rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : 32'h0000_0000;
  assign opcode      = instr[6:0];

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RV32I core, directly upstream of the control unit and decoder. Holds the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions with their PCs in a 2-entry FIFO. Presents instructions to decode over a valid/ready interface. Branch/jump redirects from execute flush all in-flight and buffered work.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2)
- clk  in  1  core clock
- reset_n  in  1  reset; asynchronous, active-low
- en_pc  in  1  fetch enable from control unit; low blocks new requests
- imem_req  out  1  request valid to instruction memory
- imem_addr  out  32  word address of request, bits [1:0] always 0
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (≥1 cycle after gnt)
- imem_rdata  in  32  read data
- redirect_valid  in  1  taken branch/jal/jalr, one-cycle pulse
- redirect_pc  in  32  redirect target
- instr_valid  out  1  instr/instr_pc valid to decode
- instr_ready  in  1  decode accepts
- instr  out  32  instruction word
- instr_pc  out  32  PC of instr
- opcode  out  7  instr[6:0], feeds control unit
- misalign_fault  out  1  misaligned redirect target (see Configuration)

## Operation
- Registers: fetch_pc, FSM state, FIFO (pc+word per entry), count, outstanding (0/1).
- At most one outstanding memory request.
- Issue condition: en_pc=1 and count + outstanding < FIFO_DEPTH.
- FSM states:
  - IDLE: imem_req=0. Goes to REQ when issue condition holds.
  - REQ: imem_req=1, imem_addr=fetch_pc. On gnt: fetch_pc += 4 (wraps mod 2^32), go to WAIT. Without gnt, stay in REQ; imem_addr is held stable unless a redirect occurs.
  - WAIT: on rvalid, push {fetch_pc−4, rdata}. Then go to REQ if the issue condition holds, else IDLE.
  - DROP: wait for rvalid, discard the data, then go to REQ or IDLE per the issue condition.
- Redirect has priority over every other event in the same cycle:
  - FIFO is flushed (count=0); a same-cycle pop or push is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - From REQ without gnt: stay in REQ with the new address.
  - From REQ with gnt, or from WAIT without rvalid: go to DROP.
  - From WAIT with rvalid, or from DROP with rvalid: response is discarded; go to REQ or IDLE per the issue condition.
  - From IDLE: go to REQ or IDLE per the issue condition.
- FIFO:
  - Pop on instr_valid & instr_ready; instr_valid = (count≠0).
  - Simultaneous push and pop is legal at any count.
  - Overflow is impossible by the issue rule.
- Output when empty: instr=32'h0000_0013 (NOP), instr_pc=0, opcode=7'b0010011.
- en_pc falling while a request is outstanding: that transaction completes normally; no new issue.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013, instr_pc=0, misalign_fault=0, state=IDLE, fetch_pc=RESET_PC, count=0, outstanding=0.
- Reset asserted mid-transaction: all state clears immediately. A later stray rvalid while IDLE is ignored.
- imem_req is registered: it rises the cycle after the issue condition is seen in IDLE.
- Minimum latency, with gnt in the cycle req rises and rvalid one cycle later:
  - rvalid in cycle N → instr_valid in cycle N+1.
  - Redirect in cycle R → imem_req with the new address in R+1, instr_valid in R+3.
- Sustained throughput: one instruction per 2 cycles with single-outstanding memory (REQ→WAIT→REQ).
- Outputs are registered from FIFO head; no combinational path from instr_ready to imem_req.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - redirect with redirect_pc[1:0]≠0 sets misalign_fault=1 and flushes as normal.
  - FSM then holds in IDLE; no requests issue.
  - misalign_fault stays high until a later aligned redirect clears it and resumes fetch.
- FETCH_MISALIGN_TRAP_EN undefined: misalign_fault tied 0; redirect_pc[1:0] silently forced to 0.

## Test plan
- Reset release, en_pc=1, memory with gnt same cycle and rvalid +1 → fetches 0x0, 0x4, 0x8; instr_valid with instr_pc=0x0 first; opcode=rdata[6:0].
- instr_ready=0 held → exactly 2 entries buffered, imem_req stays 0. Raise ready → 2 pops in order, fetch resumes at 0x8.
- Redirect to 0x100 in the same cycle as gnt for 0xC → rvalid for 0xC discarded (DROP). Next instr_pc=0x100; FIFO empty the cycle after redirect.
- Redirect coincident with a pop and an rvalid push → FIFO empty, no stale entry, next request addr=redirect target.
- fetch_pc=0xFFFF_FFFC → next request addr=0x0000_0000 (wrap).
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 → misalign_fault=1, no imem_req. Redirect to 0x200 → fault clears, fetch 0x200. Without the macro: same redirect fetches 0x100, fault=0.
